// File: rtl/dpp_table.sv
// Dining-philosophers table: one thinking/hungry/eating FSM per philosopher plus a
// round-robin fork arbiter that hands out at most one pair of forks per clock edge.

`ifndef PHILO_STATE_SIZE
`define PHILO_STATE_SIZE 2
`endif
`ifndef PHILO_THINKING
`define PHILO_THINKING 2'b01
`endif
`ifndef PHILO_HUNGRY
`define PHILO_HUNGRY 2'b00
`endif
`ifndef PHILO_EATING
`define PHILO_EATING 2'b10
`endif

module dpp_table #(
    parameter int N_PHILO    = 5,
    parameter int TIMER_SIZE = 4,
    parameter int THINK_TIME = 5,
    parameter int THINK_STEP = 1,
    parameter int EAT_TIME   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pause,
    output logic [N_PHILO*`PHILO_STATE_SIZE-1:0]  state,
    output logic [N_PHILO-1:0]                    fork_busy,
    output logic [N_PHILO-1:0]                    grant,
    output logic [N_PHILO-1:0]                    eat_done
);

    localparam int PTR_W = (N_PHILO > 1) ? $clog2(N_PHILO) : 1;
    localparam int SW    = `PHILO_STATE_SIZE;

    logic [N_PHILO*SW-1:0]   st_q, st_d;
    logic [TIMER_SIZE-1:0]   tmr_q [N_PHILO];
    logic [TIMER_SIZE-1:0]   tmr_d [N_PHILO];
    logic [N_PHILO-1:0]      fork_q, fork_d;
    logic [N_PHILO-1:0]      gnt_d, done_d, elig;
    logic [N_PHILO-1:0]      grant_q, eat_done_q;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    found;

    function automatic logic [TIMER_SIZE-1:0] think_last(input int i);
        return TIMER_SIZE'(THINK_TIME + i * THINK_STEP - 1);
    endfunction

    // Arbiter: two passes (indices >= pointer, then below it) give a rotating
    // priority while keeping every array index a loop constant.
    always_comb begin
        elig  = '0;
        gnt_d = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < N_PHILO; i++) begin
            elig[i] = (st_q[i*SW +: SW] == `PHILO_HUNGRY) && !fork_q[i] && !fork_q[(i + 1) % N_PHILO];
        end
        if (!pause) begin
            for (int i = 0; i < N_PHILO; i++) begin
                if (!found && elig[i] && (i >= int'(ptr_q))) begin
                    found    = 1'b1;
                    gnt_d[i] = 1'b1;
                    ptr_d    = PTR_W'((i + 1) % N_PHILO);
                end
            end
            for (int i = 0; i < N_PHILO; i++) begin
                if (!found && elig[i] && (i < int'(ptr_q))) begin
                    found    = 1'b1;
                    gnt_d[i] = 1'b1;
                    ptr_d    = PTR_W'((i + 1) % N_PHILO);
                end
            end
        end
    end

    // Philosopher FSMs and their timers.
    always_comb begin
        st_d   = st_q;
        done_d = '0;
        for (int i = 0; i < N_PHILO; i++) begin
            tmr_d[i] = tmr_q[i];
            if (!pause) begin
                case (st_q[i*SW +: SW])
                    `PHILO_THINKING: begin
                        if (tmr_q[i] == think_last(i)) begin
                            st_d[i*SW +: SW] = `PHILO_HUNGRY;
                            tmr_d[i]         = '0;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    `PHILO_HUNGRY: begin
                        if (gnt_d[i]) begin
                            st_d[i*SW +: SW] = `PHILO_EATING;
                            tmr_d[i]         = '0;
                        end
                    end
                    `PHILO_EATING: begin
                        if (tmr_q[i] == TIMER_SIZE'(EAT_TIME - 1)) begin
                            st_d[i*SW +: SW] = `PHILO_THINKING;
                            tmr_d[i]         = '0;
                            done_d[i]        = 1'b1;
                        end else begin
                            tmr_d[i] = tmr_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        st_d[i*SW +: SW] = `PHILO_THINKING;
                        tmr_d[i]         = '0;
                    end
                endcase
            end
        end
    end

    // A granted pair is free in fork_q, so it never overlaps a pair being released.
    always_comb begin
        fork_d = fork_q;
        for (int i = 0; i < N_PHILO; i++) begin
            if (done_d[i]) begin
                fork_d[i]                 = 1'b0;
                fork_d[(i + 1) % N_PHILO] = 1'b0;
            end
        end
        for (int i = 0; i < N_PHILO; i++) begin
            if (gnt_d[i]) begin
                fork_d[i]                 = 1'b1;
                fork_d[(i + 1) % N_PHILO] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= {N_PHILO{`PHILO_THINKING}};
            fork_q     <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            eat_done_q <= '0;
            for (int i = 0; i < N_PHILO; i++) begin
                tmr_q[i] <= '0;
            end
        end else begin
            st_q       <= st_d;
            fork_q     <= fork_d;
            ptr_q      <= ptr_d;
            grant_q    <= gnt_d;
            eat_done_q <= done_d;
            for (int i = 0; i < N_PHILO; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
        end
    end

    assign state     = st_q;
    assign fork_busy = fork_q;
    assign grant     = grant_q;
    assign eat_done  = eat_done_q;

endmodule

// File: tb/tb_dpp_table.sv
// Directed bench for dpp_table: two tables (THINK_STEP=1 and THINK_STEP=0) run side by
// side against hand-derived grant/eat_done schedules, plus pause, reset and long-run checks.

module tb_dpp_table;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pause_a = 1'b0;
    logic           pause_b = 1'b0;
    logic [2*N-1:0] state_a, state_b;
    logic [N-1:0]   fb_a, fb_b, g_a, g_b, ed_a, ed_b;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit cnt_en = 1'b0;
    int gcnt_a [N];
    int gcnt_b [N];

    // Expected per-edge pulses for edges 1..13 after reset release.
    logic [N-1:0] exp_ga  [1:13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00,
                                     5'h04, 5'h00, 5'h10, 5'h02, 5'h00, 5'h08};
    logic [N-1:0] exp_eda [1:13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                                     5'h01, 5'h00, 5'h04, 5'h00, 5'h10, 5'h02};
    logic [N-1:0] exp_gb  [1:13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h04,
                                     5'h00, 5'h10, 5'h02, 5'h00, 5'h08, 5'h00};
    logic [N-1:0] exp_edb [1:13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                                     5'h01, 5'h04, 5'h00, 5'h10, 5'h02, 5'h00};

    always #5 clk = ~clk;

    dpp_table #(.N_PHILO(N), .TIMER_SIZE(4), .THINK_TIME(5), .THINK_STEP(1), .EAT_TIME(2)) u_a (
        .clk(clk), .reset(reset), .pause(pause_a),
        .state(state_a), .fork_busy(fb_a), .grant(g_a), .eat_done(ed_a)
    );

    dpp_table #(.N_PHILO(N), .TIMER_SIZE(4), .THINK_TIME(5), .THINK_STEP(0), .EAT_TIME(2)) u_b (
        .clk(clk), .reset(reset), .pause(pause_b),
        .state(state_b), .fork_busy(fb_b), .grant(g_b), .eat_done(ed_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv(input string nm, input logic [2*N-1:0] st, input logic [N-1:0] fb,
                       input logic [N-1:0] g);
        logic [N-1:0] eat;
        logic [N-1:0] fm;
        for (int k = 0; k < N; k++) eat[k] = (st[2*k +: 2] == 2'b10);
        for (int k = 0; k < N; k++) fm[k] = eat[k] | eat[(k + N - 1) % N];
        check({nm, "_fork_owner"}, fb, fm);
        check({nm, "_adjacent_eating"}, eat & {eat[0], eat[N-1:1]}, 0);
        check({nm, "_grant_onehot"}, $countones(g) <= 1, 1);
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            inv("a", state_a, fb_a, g_a);
            inv("b", state_b, fb_b, g_b);
            if (cnt_en) begin
                for (int i = 0; i < N; i++) begin
                    gcnt_a[i] += int'(g_a[i]);
                    gcnt_b[i] += int'(g_b[i]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            gcnt_a[i] = 0;
            gcnt_b[i] = 0;
        end

        // Reset state
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_state_a", state_a, 10'h155);
        check("rst_state_b", state_b, 10'h155);
        check("rst_fork_a", fb_a, 0);
        check("rst_grant_a", g_a, 0);
        check("rst_eat_done_b", ed_b, 0);
        reset = 1'b0;

        // Free run, edges 1..13
        for (int e = 1; e <= 13; e++) begin
            tick();
            check($sformatf("grant_a_e%0d", e), g_a, exp_ga[e]);
            check($sformatf("eat_done_a_e%0d", e), ed_a, exp_eda[e]);
            check($sformatf("grant_b_e%0d", e), g_b, exp_gb[e]);
            check($sformatf("eat_done_b_e%0d", e), ed_b, exp_edb[e]);
            if (e == 5) begin
                check("state_a_e5", state_a, 10'b01_01_01_01_00);
                check("state_b_e5", state_b, 10'b00_00_00_00_00);
            end
            if (e == 6) begin
                check("state_b_e6", state_b, 10'b00_00_00_00_10);
                check("fork_a_e6", fb_a, 5'b00011);
            end
            if (e == 13) begin
                check("state_a_e13", state_a, 10'b01_10_01_01_00);
                check("fork_a_e13", fb_a, 5'b11000);
            end
        end

        // Pause a mid-meal for 10 edges
        pause_a = 1'b1;
        for (int p = 0; p < 10; p++) begin
            tick();
            check($sformatf("pause_state_%0d", p), state_a, 10'b01_10_01_01_00);
            check($sformatf("pause_fork_%0d", p), fb_a, 5'b11000);
            check($sformatf("pause_grant_%0d", p), g_a, 0);
            check($sformatf("pause_eat_done_%0d", p), ed_a, 0);
        end
        pause_a = 1'b0;
        tick();
        check("resume1_grant", g_a, 5'b00001);
        check("resume1_eat_done", ed_a, 0);
        check("resume1_state", state_a, 10'b01_10_01_01_10);
        tick();
        check("resume2_eat_done", ed_a, 5'b01000);
        check("resume2_grant", g_a, 0);
        check("resume2_fork", fb_a, 5'b00011);

        // Reset while a is mid-meal
        reset = 1'b1;
        tick();
        check("rst_meal_state_a", state_a, 10'h155);
        check("rst_meal_fork_a", fb_a, 0);
        reset = 1'b0;

        // Run to edge 10 where b has two eaters, then reset
        for (int e = 1; e <= 10; e++) tick();
        check("pre_rst_state_b", state_b, 10'b10_00_01_10_01);
        check("pre_rst_fork_b", fb_b, 5'b10111);
        check("pre_rst_state_a", state_a, 10'b10_00_01_00_01);
        reset = 1'b1;
        tick();
        check("rst2_state_b", state_b, 10'h155);
        check("rst2_fork_b", fb_b, 0);
        check("rst2_grant_b", g_b, 0);
        check("rst2_eat_done_b", ed_b, 0);
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        check("rst2_ptr_grant_b", g_b, 5'b00001);
        check("rst2_ptr_grant_a", g_a, 5'b00001);

        // Long run with random pause; invariants checked every cycle
        cnt_en = 1'b1;
        repeat (10000) begin
            tick();
            pause_a = ($urandom_range(0, 3) == 0);
            pause_b = ($urandom_range(0, 3) == 0);
        end
        pause_a = 1'b0;
        pause_b = 1'b0;
        tick();
        cnt_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("no_starve_a%0d", i), gcnt_a[i] > 0, 1);
            check($sformatf("no_starve_b%0d", i), gcnt_b[i] > 0, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpp_table.md
# dpp_table

Parametrised dining-philosophers table: N_PHILO philosopher FSMs (thinking/hungry/eating) with per-philosopher think/eat timers, plus a central fork arbiter that grants forks with round-robin fairness. It supersedes the single-philosopher block, which had no fork ownership and no timed transitions. It sits beside the DPP event logic and drives the per-philosopher LED/state outputs.

## Interface
- N_PHILO, 5, number of philosophers and forks (>= 2)
- TIMER_SIZE, 4, width of each philosopher's cycle timer
- THINK_TIME, 5, base thinking duration in cycles (>= 1)
- THINK_STEP, 1, extra thinking cycles per philosopher index; philosopher i thinks THINK_TIME + i*THINK_STEP cycles, which must be <= 2^TIMER_SIZE-1
- EAT_TIME, 2, eating duration in cycles (1..2^TIMER_SIZE-1)
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- pause  in  1  1 = freeze all timers, block all grants; states hold
- state  out  N_PHILO*`PHILO_STATE_SIZE  philosopher i state at bits [i*2 +: 2]; `thinking=01, `hungry=00, `eating=10
- fork_busy  out  N_PHILO  bit k = fork k held
- grant  out  N_PHILO  one-hot pulse, one cycle: philosopher i granted at this edge
- eat_done  out  N_PHILO  one-cycle pulse: philosopher i left eating at this edge

## Operation
- Fork topology: philosopher i uses fork i (left) and fork (i+1) mod N_PHILO (right).
- Reset (clk edge with reset=1): all states `thinking, all timers 0, fork_busy=0, grant=0, eat_done=0, round-robin pointer=0. Reset overrides everything, including mid-meal; forks are freed immediately.
- thinking: timer increments each unpaused cycle; on the edge where timer == think_time(i)-1, state -> `hungry, timer -> 0.
- hungry: eligible when both forks are free in the registered fork_busy. Arbiter scans philosophers from pointer upward (mod N). It grants the first eligible philosopher: at most one grant per edge. On grant: state -> `eating, both forks set busy, timer -> 0, grant[i]=1 for one cycle, pointer -> (i+1) mod N. No eligible philosopher: pointer unchanged.
- eating: timer increments; on the edge where timer == EAT_TIME-1, state -> `thinking, both forks cleared, timer -> 0, eat_done[i]=1 for one cycle.
- Arbitration reads registered fork_busy only. A fork released at edge t can be granted no earlier than edge t+1.
- pause=1: timers, states, forks and pointer hold; grant/eat_done are 0.
- Invariants: no fork held by two philosophers; adjacent philosophers never both `eating; popcount(grant) <= 1.

## Timing
- Edges counted 1, 2, … after reset deasserts.
- With pause=0, thinking lasts exactly think_time(i) edges, eating exactly EAT_TIME edges, hungry >= 1 edge.
- Output latency: state, fork_busy, grant and eat_done are all registered and update on the same edge as the transition.
- Timer width: timers never exceed their terminal count, so no wrap occurs.

## Test plan
- Reset then run with N=5, THINK=5, STEP=1, EAT=2 -> philosopher 0 `hungry after edge 5, granted at edge 6, `eating after edges 6–7, eat_done[0] at edge 8. Philosopher 1 `hungry after edge 6, blocked, granted at edge 11.
- STEP=0, all hungry after edge 5 -> grants at edge 6 (P0) and edge 7 (P2). No grant at edge 8. Edge 9 grants P4 (P3 is still blocked by fork 3, released that same edge).
- Fork release and same-edge request: fork freed at edge t -> neighbour grant observed at edge t+1, never t.
- pause held for 10 cycles mid-meal -> state, timers and fork_busy frozen; meal resumes and completes with its remaining cycles after pause drops.
- reset asserted while two philosophers are eating -> next edge: all `thinking, fork_busy=0, pointer 0.
- Long random-pause run (10k cycles) -> invariants always hold; every philosopher is granted (no starvation).
